core_debug_loader: RTL and testbench
====================================

CORE_DEBUG_LOADER -- requirements
Module: core_debug_loader

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 65535, idle cycles allowed between bytes inside a frame before the frame is aborted.
REQ-002 CPU_CLK  in  1  clock; all state changes on its rising edge.
REQ-003 CPU_RST  in  1  reset, asynchronous, active-high.
REQ-004 rx_valid  in  1  host byte valid.
REQ-005 rx_data  in  8  host byte.
REQ-006 rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both high.
REQ-007 tx_valid  out  1  response byte valid.
REQ-008 tx_data  out  8  response byte.
REQ-009 tx_ready  in  1  host accepts the response byte.
REQ-010 core_rst  out  1  reset to the core, active-high.
REQ-011 iram_a2, iram_wd2  out  32 each  instruction RAM debug address and write data.
REQ-012 iram_we2  out  4  instruction RAM debug byte enables.
REQ-013 dram_a2, dram_wd2  out  32 each  data RAM debug address and write data.
REQ-014 dram_we2  out  4  data RAM debug byte enables.
REQ-015 dram_rd2  in  32  data RAM debug read data; valid one cycle after dram_a2 is presented.
REQ-016 busy  out  1  high in any state other than S_CMD.
REQ-017 err  out  1  sticky error flag.

Function
REQ-018 Frame format: cmd byte, then 4 address bytes (LSB first), then 2 count bytes (LSB first, N words), then payload.
REQ-019 Commands are 0x00 CLR (clear err), 0x01 LOAD_I, 0x02 LOAD_D, 0x03 READ_D, 0x04 RUN (core_rst<=0) and 0x05 HALT (core_rst<=1); CLR, RUN and HALT are single-byte frames.
REQ-020 Any other cmd value sets err; the FSM stays in S_CMD and the byte is discarded.
REQ-021 FSM states are S_CMD, S_ADDR, S_CNT, S_DATA, S_RREQ and S_RSEND; addr and cnt byte counters select the byte lanes.
REQ-022 Accepting a 0x01, 0x02 or 0x03 cmd byte forces core_rst=1 on the next edge, and core_rst stays 1 until a RUN command.
REQ-023 After the count is received, N=0 returns the FSM to S_CMD with no RAM access.
REQ-024 In S_DATA, bytes are packed little-endian (first byte into [7:0]); after the 4th byte is accepted, the selected RAM's a2/wd2 carry the word and we2=4'b1111 for exactly one cycle, on the following cycle.
REQ-025 The address advances by 4 per word, mod 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-026 rx_ready stays high during the write cycle, so back-to-back bytes lose no throughput.
REQ-027 After word N is written, the FSM returns to S_CMD.
REQ-028 In READ_D, S_RREQ drives dram_a2 for one cycle, then captures dram_rd2.
REQ-029 S_RSEND then emits the 4 bytes LSB first; each byte is held with tx_valid=1 until tx_ready, and the address advances by 4.
REQ-030 After word N is sent, the FSM returns to S_CMD.
REQ-031 rx_ready=1 in S_CMD, S_ADDR, S_CNT and S_DATA, and 0 in S_RREQ and S_RSEND.
REQ-032 tx_valid=0 outside S_RSEND.
REQ-033 we2 is 0 on both RAM ports except during write pulses, and only the port selected by cmd is ever pulsed.
REQ-034 Timeout: in S_ADDR, S_CNT or S_DATA, a cycle counter is cleared on each accepted byte.
REQ-035 When the timeout counter reaches TIMEOUT_CYCLES, the FSM aborts to S_CMD, sets err, and discards any partial word unwritten; previously written words remain.
REQ-036 Timeout is not counted in S_RREQ or S_RSEND; tx back-pressure may stall indefinitely.
REQ-037 If a write pulse and a timeout fall in the same cycle, the write completes and the abort takes effect afterwards.
REQ-038 err is set only by an illegal cmd or a timeout, is cleared only by CLR or CPU_RST, and a set takes priority over a clear in the same cycle.
REQ-039 The count is 16-bit unsigned, so N ranges from 0 to 65535 words.

Reset
REQ-040 While CPU_RST=1, the FSM is S_CMD; core_rst=1; rx_ready, tx_valid, busy and err are 0; all a2/wd2/tx_data are 0; and both we2 are 4'b0000.
REQ-041 rx_ready rises on the first CPU_CLK edge after CPU_RST deasserts.
REQ-042 CPU_RST asserted mid-frame aborts immediately with no further we2 pulse, and the partial word is lost.

Verification
REQ-043 Scenario: stream 01,00,00,00,00,02,00,13,00,00,00,93,00,10,00 -> iram_we2=F pulses with a2=0x0 and wd2=0x00000013, then a2=0x4 and wd2=0x00100093; core_rst stays 1.
REQ-044 Scenario: LOAD_D to 0x10 with 1 word 0xDEADBEEF, then READ_D to 0x10 with N=1, with tx_ready toggling -> tx bytes EF,BE,AD,DE in order and no byte dropped or duplicated.
REQ-045 Scenario: LOAD_I to 0xFFFFFFFC with N=2 -> writes at 0xFFFFFFFC then 0x00000000.
REQ-046 Scenario: with TIMEOUT_CYCLES=16, send 01 plus 2 address bytes, then idle for 16 cycles -> err=1, busy=0, and no we2 pulse; then CLR -> err=0.
REQ-047 Scenario: send byte 0x7F -> err=1 with the FSM in S_CMD; then 04 -> core_rst=0; then 01 -> core_rst=1 on the next cycle.
REQ-048 Scenario: assert CPU_RST after 2 of 4 data bytes -> no we2 pulse; core_rst=1 and outputs at their REQ-040 values.

Source files
------------

// File: rtl/core_debug_loader.sv
// Byte-stream debug loader: host frames load or read the core's instruction and data RAMs
// through their second ports, and control the core reset.
module core_debug_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        core_rst,
  output logic [31:0] iram_a2,
  output logic [31:0] iram_wd2,
  output logic [3:0]  iram_we2,
  output logic [31:0] dram_a2,
  output logic [31:0] dram_wd2,
  output logic [3:0]  dram_we2,
  input  logic [31:0] dram_rd2,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] S_CMD   = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_CNT   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_RREQ  = 3'd4;
  localparam logic [2:0] S_RSEND = 3'd5;

  localparam logic [7:0] C_CLR    = 8'h00;
  localparam logic [7:0] C_LOAD_I = 8'h01;
  localparam logic [7:0] C_LOAD_D = 8'h02;
  localparam logic [7:0] C_READ_D = 8'h03;
  localparam logic [7:0] C_RUN    = 8'h04;
  localparam logic [7:0] C_HALT   = 8'h05;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] tmo_q, tmo_d;
  logic        rph_q, rph_d;
  logic        core_rst_q, core_rst_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        rx_ready_q, rx_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] iram_a2_q, iram_a2_d, iram_wd2_q, iram_wd2_d;
  logic [3:0]  iram_we2_q, iram_we2_d;
  logic [31:0] dram_a2_q, dram_a2_d, dram_wd2_q, dram_wd2_d;
  logic [3:0]  dram_we2_q, dram_we2_d;
  logic        accept, err_set, err_clr;

  // Frame decode, RAM access sequencing and idle timeout.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    tmo_d      = tmo_q;
    rph_d      = rph_q;
    core_rst_d = core_rst_q;
    tx_data_d  = tx_data_q;
    iram_a2_d  = iram_a2_q;
    iram_wd2_d = iram_wd2_q;
    iram_we2_d = 4'b0000;
    dram_a2_d  = dram_a2_q;
    dram_wd2_d = dram_wd2_q;
    dram_we2_d = 4'b0000;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    accept     = rx_valid & rx_ready_q;

    case (state_q)
      S_CMD: begin
        if (accept) begin
          case (rx_data)
            C_CLR:  err_clr = 1'b1;
            C_RUN:  core_rst_d = 1'b0;
            C_HALT: core_rst_d = 1'b1;
            C_LOAD_I, C_LOAD_D, C_READ_D: begin
              core_rst_d = 1'b1;
              cmd_d      = rx_data[1:0];
              idx_d      = 2'd0;
              tmo_d      = '0;
              state_d    = S_ADDR;
            end
            default: err_set = 1'b1;
          endcase
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_d[{idx_q, 3'b000} +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_CNT;
        end
      end
      S_CNT: begin
        if (accept) begin
          if (idx_q == 2'd0) begin
            cnt_d[7:0] = rx_data;
            idx_d      = 2'd1;
          end else begin
            cnt_d[15:8] = rx_data;
            idx_d       = 2'd0;
            if ({rx_data, cnt_q[7:0]} == 16'd0) begin
              state_d = S_CMD;
            end else if (cmd_q == 2'b11) begin
              dram_a2_d = addr_q;
              rph_d     = 1'b0;
              state_d   = S_RREQ;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d[{idx_q, 3'b000} +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (cmd_q == 2'b01) begin
              iram_a2_d  = addr_q;
              iram_wd2_d = {rx_data, word_q[23:0]};
              iram_we2_d = 4'b1111;
            end else begin
              dram_a2_d  = addr_q;
              dram_wd2_d = {rx_data, word_q[23:0]};
              dram_we2_d = 4'b1111;
            end
            addr_d = addr_q + 32'd4;
            cnt_d  = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = S_CMD;
          end
        end
      end
      S_RREQ: begin
        // Address was presented last cycle; read data is valid in this one.
        rph_d = 1'b1;
        if (rph_q) begin
          word_d    = dram_rd2;
          tx_data_d = dram_rd2[7:0];
          idx_d     = 2'd0;
          state_d   = S_RSEND;
        end
      end
      S_RSEND: begin
        if (tx_valid_q && tx_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            addr_d = addr_q + 32'd4;
            cnt_d  = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              state_d = S_CMD;
            end else begin
              dram_a2_d = addr_q + 32'd4;
              rph_d     = 1'b0;
              state_d   = S_RREQ;
            end
          end else begin
            tx_data_d = word_q[{2'(idx_q + 2'd1), 3'b000} +: 8];
          end
        end
      end
      default: state_d = S_CMD;
    endcase

    // Idle timeout only while the host owes us bytes; a pending partial word is dropped.
    if (state_q == S_ADDR || state_q == S_CNT || state_q == S_DATA) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q >= TMO_LAST) begin
        tmo_d   = '0;
        idx_d   = 2'd0;
        err_set = 1'b1;
        state_d = S_CMD;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end

    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;

    rx_ready_d = (state_d == S_CMD) || (state_d == S_ADDR) ||
                 (state_d == S_CNT) || (state_d == S_DATA);
    tx_valid_d = (state_d == S_RSEND);
    busy_d     = (state_d != S_CMD);
  end

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state_q    <= S_CMD;
      cmd_q      <= 2'b00;
      idx_q      <= 2'd0;
      addr_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      tmo_q      <= '0;
      rph_q      <= 1'b0;
      core_rst_q <= 1'b1;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      iram_a2_q  <= '0;
      iram_wd2_q <= '0;
      iram_we2_q <= 4'b0000;
      dram_a2_q  <= '0;
      dram_wd2_q <= '0;
      dram_we2_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      tmo_q      <= tmo_d;
      rph_q      <= rph_d;
      core_rst_q <= core_rst_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      iram_a2_q  <= iram_a2_d;
      iram_wd2_q <= iram_wd2_d;
      iram_we2_q <= iram_we2_d;
      dram_a2_q  <= dram_a2_d;
      dram_wd2_q <= dram_wd2_d;
      dram_we2_q <= dram_we2_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign core_rst = core_rst_q;
  assign iram_a2  = iram_a2_q;
  assign iram_wd2 = iram_wd2_q;
  assign iram_we2 = iram_we2_q;
  assign dram_a2  = dram_a2_q;
  assign dram_wd2 = dram_wd2_q;
  assign dram_we2 = dram_we2_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_core_debug_loader.sv
// Directed bench for core_debug_loader: command table plus load, read-back, wrap,
// timeout and mid-frame reset sequences against a small data RAM model.
module tb_core_debug_loader;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST;
  logic        rx_valid, rx_ready, tx_valid, tx_ready, core_rst, busy, err;
  logic [7:0]  rx_data, tx_data;
  logic [31:0] iram_a2, iram_wd2, dram_a2, dram_wd2, dram_rd2;
  logic [3:0]  iram_we2, dram_we2;

  int n_tests = 0;
  int n_fail  = 0;
  int proto_err = 0;
  logic tx_tog = 1'b0;

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] we; } wr_t;
  typedef struct { logic [7:0] b; logic err; logic crst; logic busy; } vec_t;

  wr_t         iwr[$];
  wr_t         dwr[$];
  logic [7:0]  txq[$];
  logic [7:0]  sq[$];
  logic [31:0] dmem[logic [31:0]];
  vec_t        vt[17];

  core_debug_loader #(.TIMEOUT_CYCLES(16)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .core_rst(core_rst),
    .iram_a2(iram_a2), .iram_wd2(iram_wd2), .iram_we2(iram_we2),
    .dram_a2(dram_a2), .dram_wd2(dram_wd2), .dram_we2(dram_we2),
    .dram_rd2(dram_rd2), .busy(busy), .err(err)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  // Host response acceptance: steady or toggling every cycle.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge CPU_CLK);
      #1;
      tx_ready = tx_tog ? ~tx_ready : 1'b1;
    end
  end

  // Synchronous data RAM: address sampled at an edge, data valid the following cycle.
  initial begin
    logic [31:0] ra, rwd;
    logic [3:0]  rwe;
    dram_rd2 = '0;
    forever begin
      @(negedge CPU_CLK);
      ra = dram_a2; rwe = dram_we2; rwd = dram_wd2;
      @(posedge CPU_CLK);
      #1;
      if (rwe == 4'hF) dmem[ra] = rwd;
      dram_rd2 = dmem.exists(ra) ? dmem[ra] : 32'h0;
    end
  end

  // Monitor: every write-pulse cycle, every tx handshake, rx_ready during a response.
  initial begin
    forever begin
      @(negedge CPU_CLK);
      if (iram_we2 != 4'h0) iwr.push_back('{iram_a2, iram_wd2, iram_we2});
      if (dram_we2 != 4'h0) dwr.push_back('{dram_a2, dram_wd2, dram_we2});
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (tx_valid && rx_ready) proto_err++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge CPU_CLK);
    while (!rx_ready && t < 100) begin
      @(negedge CPU_CLK);
      t++;
    end
    if (!rx_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_wait: rx_ready got 0 expected 1");
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge CPU_CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_q();
    foreach (sq[i]) send(sq[i]);
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    @(negedge CPU_CLK);
    while (busy && t < 1000) begin
      @(negedge CPU_CLK);
      t++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_idle: busy got 1 expected 0", nm);
    end
  endtask

  task automatic check_rst_vals(input string nm);
    chk({nm, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({nm, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({nm, "_busy"},     32'(busy),     32'd0);
    chk({nm, "_err"},      32'(err),      32'd0);
    chk({nm, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({nm, "_tx_data"},  32'(tx_data),  32'd0);
    chk({nm, "_iram_a2"},  iram_a2,       32'd0);
    chk({nm, "_iram_wd2"}, iram_wd2,      32'd0);
    chk({nm, "_iram_we2"}, 32'(iram_we2), 32'd0);
    chk({nm, "_dram_a2"},  dram_a2,       32'd0);
    chk({nm, "_dram_wd2"}, dram_wd2,      32'd0);
    chk({nm, "_dram_we2"}, 32'(dram_we2), 32'd0);
  endtask

  task automatic chk_wr(input string nm, input wr_t w, input logic [31:0] a, input logic [31:0] d);
    chk({nm, "_a2"},  w.a,       a);
    chk({nm, "_wd2"}, w.d,       d);
    chk({nm, "_we2"}, 32'(w.we), 32'hF);
  endtask

  initial begin
    logic [7:0] exp_tx[8];
    int t;

    // {byte, err, core_rst, busy} seen one cycle after the byte is accepted
    vt[0]  = '{8'h05, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{8'h04, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{8'h7F, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{8'h00, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{8'h06, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{8'h04, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{8'h00, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{8'h01, 1'b0, 1'b1, 1'b1};
    vt[8]  = '{8'h00, 1'b0, 1'b1, 1'b1};
    vt[9]  = '{8'h01, 1'b0, 1'b1, 1'b1};
    vt[10] = '{8'h00, 1'b0, 1'b1, 1'b1};
    vt[11] = '{8'h00, 1'b0, 1'b1, 1'b1};
    vt[12] = '{8'h00, 1'b0, 1'b1, 1'b1};
    vt[13] = '{8'h00, 1'b0, 1'b1, 1'b0};
    vt[14] = '{8'h05, 1'b0, 1'b1, 1'b0};
    vt[15] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vt[16] = '{8'h00, 1'b0, 1'b1, 1'b0};

    CPU_RST  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge CPU_CLK);
    check_rst_vals("reset");
    CPU_RST = 1'b0;
    #1 chk("rx_ready_pre_edge", 32'(rx_ready), 32'd0);
    @(negedge CPU_CLK);
    chk("rx_ready_after_reset", 32'(rx_ready), 32'd1);

    for (int i = 0; i < 17; i++) begin
      send(vt[i].b);
      @(negedge CPU_CLK);
      chk($sformatf("vec%0d_err", i),      32'(err),      32'(vt[i].err));
      chk($sformatf("vec%0d_core_rst", i), 32'(core_rst), 32'(vt[i].crst));
      chk($sformatf("vec%0d_busy", i),     32'(busy),     32'(vt[i].busy));
      chk($sformatf("vec%0d_rx_ready", i), 32'(rx_ready), 32'd1);
    end
    chk("table_no_iram_wr", 32'(iwr.size()), 32'd0);
    chk("table_no_dram_wr", 32'(dwr.size()), 32'd0);

    // Two-word instruction load, streamed back to back.
    sq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
           8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_q();
    repeat (3) @(negedge CPU_CLK);
    chk("ld_i_count", 32'(iwr.size()), 32'd2);
    if (iwr.size() == 2) begin
      chk_wr("ld_i_w0", iwr[0], 32'h0, 32'h00000013);
      chk_wr("ld_i_w1", iwr[1], 32'h4, 32'h00100093);
    end
    chk("ld_i_no_dram", 32'(dwr.size()), 32'd0);
    chk("ld_i_core_rst", 32'(core_rst), 32'd1);
    chk("ld_i_busy", 32'(busy), 32'd0);
    iwr.delete();

    // Address wrap at the top of the address space.
    sq = '{8'h01, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00,
           8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    send_q();
    repeat (3) @(negedge CPU_CLK);
    chk("wrap_count", 32'(iwr.size()), 32'd2);
    if (iwr.size() == 2) begin
      chk_wr("wrap_w0", iwr[0], 32'hFFFFFFFC, 32'h11223344);
      chk_wr("wrap_w1", iwr[1], 32'h00000000, 32'h55667788);
    end
    iwr.delete();

    // Data load then read-back under toggling tx_ready.
    sq = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send_q();
    repeat (3) @(negedge CPU_CLK);
    chk("ld_d_count", 32'(dwr.size()), 32'd2);
    if (dwr.size() == 2) begin
      chk_wr("ld_d_w0", dwr[0], 32'h10, 32'hDEADBEEF);
      chk_wr("ld_d_w1", dwr[1], 32'h14, 32'hCAFEF00D);
    end
    chk("ld_d_no_iram", 32'(iwr.size()), 32'd0);
    dwr.delete();
    txq.delete();
    tx_tog = 1'b1;
    sq = '{8'h03, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
    send_q();
    t = 0;
    while (txq.size() < 8 && t < 500) begin
      @(negedge CPU_CLK);
      t++;
    end
    wait_idle("rd");
    repeat (6) @(negedge CPU_CLK);
    tx_tog = 1'b0;
    exp_tx = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    chk("rd_byte_count", 32'(txq.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < txq.size()) chk($sformatf("rd_byte%0d", i), 32'(txq[i]), 32'(exp_tx[i]));
    chk("rd_no_writes", 32'(iwr.size() + dwr.size()), 32'd0);
    chk("rd_tx_valid_idle", 32'(tx_valid), 32'd0);
    chk("rd_rx_ready_gated", 32'(proto_err), 32'd0);

    // Timeout while receiving the address: exactly 16 idle cycles.
    sq = '{8'h01, 8'h00, 8'h00};
    send_q();
    repeat (15) @(posedge CPU_CLK);
    @(negedge CPU_CLK);
    chk("tmo_15_err", 32'(err), 32'd0);
    chk("tmo_15_busy", 32'(busy), 32'd1);
    @(negedge CPU_CLK);
    chk("tmo_16_err", 32'(err), 32'd1);
    chk("tmo_16_busy", 32'(busy), 32'd0);
    chk("tmo_no_wr", 32'(iwr.size() + dwr.size()), 32'd0);
    send(8'h00);
    @(negedge CPU_CLK);
    chk("tmo_clr_err", 32'(err), 32'd0);

    // Timeout mid-word keeps the finished word and drops the partial one.
    sq = '{8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_q();
    repeat (20) @(negedge CPU_CLK);
    chk("tmo_data_count", 32'(iwr.size()), 32'd1);
    if (iwr.size() == 1) chk_wr("tmo_data_w0", iwr[0], 32'h40, 32'h44332211);
    chk("tmo_data_err", 32'(err), 32'd1);
    chk("tmo_data_busy", 32'(busy), 32'd0);
    send(8'h00);
    iwr.delete();

    // Reset in the middle of a data word, with err set beforehand.
    sq = '{8'h7F, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_q();
    @(negedge CPU_CLK);
    chk("mid_err_before", 32'(err), 32'd1);
    CPU_RST = 1'b1;
    #1 check_rst_vals("mid_rst");
    repeat (4) @(negedge CPU_CLK);
    chk("mid_rst_no_wr", 32'(iwr.size() + dwr.size()), 32'd0);
    CPU_RST = 1'b0;
    @(negedge CPU_CLK);
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge CPU_CLK);
    chk("mid_rst_no_wr_after", 32'(iwr.size() + dwr.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
